dual_port_sram: RTL and testbench

- True dual-port synchronous RAM: two independent read/write ports (A, B) sharing one storage array on a single clock.
- Used as a general scratch or buffer memory between two agents that each need full read/write access.
- Defines deterministic behaviour for same-address collisions.
- Carries an optional protocol checker for write-write collisions.

---
 rtl/dual_port_sram_pkg.sv | 18 +
 rtl/dual_port_sram_checker.sv | 24 ++
 rtl/dual_port_sram.sv | 79 +++++++
 tb/tb_dual_port_sram.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dual_port_sram_pkg.sv
// Shared constants and types for the true dual-port synchronous RAM.
// Collision handling is fixed: on a same-address write/write, port A's data is stored.
package dual_port_sram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic [0:0] {
    PORT_A_WINS = 1'b0
  } collision_policy_e;

  localparam collision_policy_e COLLISION_POLICY = PORT_A_WINS;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/dual_port_sram_checker.sv
// Protocol checker for same-address write/write collisions (non-fatal report).
// Compiled only when DUAL_PORT_SRAM_ASSERT_EN is defined.
`ifdef DUAL_PORT_SRAM_ASSERT_EN
module dual_port_sram_checker #(
  parameter int ADDR_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  we_a,
  input logic                  we_b,
  input logic [ADDR_WIDTH-1:0] addr_a,
  input logic [ADDR_WIDTH-1:0] addr_b
);

  // flag any edge where both ports write the same word
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(we_a && we_b && (addr_a == addr_b)))
        else $error("dual_port_sram: write-write collision at %0t addr=%0h", $time, addr_a);
    end
  end

endmodule
`endif

// File: rtl/dual_port_sram.sv
// True dual-port synchronous RAM with write-first ports and port-A-wins collisions.
// Define DUAL_PORT_SRAM_ASSERT_EN to attach the write/write collision checker.
module dual_port_sram
  import dual_port_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_r;
  logic [DATA_WIDTH-1:0] dout_b_r;

  // storage update; A is assigned last so it overrides B on a shared address
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_b) begin
        mem_r[addr_b] <= din_b;
      end
      if (we_a) begin
        mem_r[addr_a] <= din_a;
      end
    end
  end

  // port A read/write-first output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a_r <= {DATA_WIDTH{1'b0}};
    end else if (we_a) begin
      dout_a_r <= din_a;
    end else begin
      dout_a_r <= mem_r[addr_a];
    end
  end

  // port B read/write-first output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_b_r <= {DATA_WIDTH{1'b0}};
    end else if (we_b) begin
      dout_b_r <= din_b;
    end else begin
      dout_b_r <= mem_r[addr_b];
    end
  end

  assign dout_a = dout_a_r;
  assign dout_b = dout_b_r;

`ifdef DUAL_PORT_SRAM_ASSERT_EN
  dual_port_sram_checker #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .clk   (clk),
    .rst   (rst),
    .we_a  (we_a),
    .we_b  (we_b),
    .addr_a(addr_a),
    .addr_b(addr_b)
  );
`else
  // default build carries no collision checker
`endif

endmodule

// File: tb/tb_dual_port_sram.sv
// Self-checking bench for dual_port_sram: directed cases plus randomized traffic
// compared against a word-array reference model with per-word "known" tracking.
module tb_dual_port_sram;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic          we_a, we_b;
  logic [DW-1:0] dout_a, dout_b;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_m [16];
  bit            known [16];

  dual_port_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr_a(addr_a),
    .din_a (din_a),
    .we_a  (we_a),
    .dout_a(dout_a),
    .addr_b(addr_b),
    .din_b (din_b),
    .we_b  (we_b),
    .dout_b(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clocked access on both ports; expectations come from the model's
  // contents before the edge (reads see old data, writers see their own din).
  task automatic cycle(input string tag,
                       input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] ea, eb;
    bit va, vb;
    we_a = wa; addr_a = aa; din_a = da;
    we_b = wb; addr_b = ab; din_b = db;
    ea = wa ? da : mem_m[aa];
    va = wa || known[aa];
    eb = wb ? db : mem_m[ab];
    vb = wb || known[ab];
    @(posedge clk);
    #1;
    if (wa && wb && aa == ab) begin
      mem_m[aa] = da;
      known[aa] = 1'b1;
    end else begin
      if (wa) begin mem_m[aa] = da; known[aa] = 1'b1; end
      if (wb) begin mem_m[ab] = db; known[ab] = 1'b1; end
    end
    if (va) check_val({tag, "_a"}, dout_a, ea);
    if (vb) check_val({tag, "_b"}, dout_b, eb);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      known[i] = 1'b0;
      mem_m[i] = 8'h00;
    end

    // reset with arbitrary stimulus present
    rst = 1'b1;
    we_a = 1'b1; addr_a = 4'h1; din_a = 8'hE1;
    we_b = 1'b1; addr_b = 4'h2; din_b = 8'hE2;
    #10;
    check_val("rst_a", dout_a, 8'h00);
    check_val("rst_b", dout_b, 8'h00);
    #2;
    rst = 1'b0;
    we_a = 1'b0; we_b = 1'b0;
    #1;
    check_val("rel_a", dout_a, 8'h00);
    check_val("rel_b", dout_b, 8'h00);

    // parallel writes then reads
    cycle("pw",  1'b1, 4'h2, 8'h1A, 1'b1, 4'h3, 8'h2B);
    cycle("pr",  1'b0, 4'h2, 8'h00, 1'b0, 4'h3, 8'h00);
    check_val("pr_a_abs", dout_a, 8'h1A);
    check_val("pr_b_abs", dout_b, 8'h2B);

    // write/write collision at 5
    cycle("ww",  1'b1, 4'h5, 8'hAA, 1'b1, 4'h5, 8'hBB);
    cycle("wwr", 1'b0, 4'h5, 8'h00, 1'b0, 4'h5, 8'h00);
    check_val("wwr_b_abs", dout_b, 8'hAA);

    // cross-port read during write
    cycle("rdw0", 1'b1, 4'h7, 8'h11, 1'b0, 4'h0, 8'h00);
    cycle("rdw1", 1'b1, 4'h7, 8'h22, 1'b0, 4'h7, 8'h00);
    check_val("rdw1_b_abs", dout_b, 8'h11);
    cycle("rdw2", 1'b0, 4'h0, 8'h00, 1'b0, 4'h7, 8'h00);
    check_val("rdw2_b_abs", dout_b, 8'h22);

    // cross access incl. top address
    cycle("xa0", 1'b1, 4'hF, 8'hC3, 1'b0, 4'h2, 8'h00);
    cycle("xa1", 1'b0, 4'h3, 8'h00, 1'b0, 4'hF, 8'h00);
    check_val("xa1_b_abs", dout_b, 8'hC3);
    cycle("xb0", 1'b0, 4'h2, 8'h00, 1'b1, 4'h0, 8'h5A);
    cycle("xb1", 1'b0, 4'h0, 8'h00, 1'b0, 4'h2, 8'h00);
    check_val("xb1_a_abs", dout_a, 8'h5A);

    // async reset in the middle of a write to 4 (4 preloaded with 10)
    cycle("pre4", 1'b1, 4'h4, 8'h10, 1'b0, 4'h3, 8'h00);
    we_a = 1'b1; addr_a = 4'h4; din_a = 8'h77;
    we_b = 1'b0; addr_b = 4'h2;
    #3;
    rst = 1'b1;
    #1;
    check_val("mrst_a", dout_a, 8'h00);
    check_val("mrst_b", dout_b, 8'h00);
    @(posedge clk);
    #1;
    check_val("mrst_hold_a", dout_a, 8'h00);
    #2;
    rst = 1'b0;
    cycle("post4", 1'b0, 4'h4, 8'h00, 1'b0, 4'h4, 8'h00);
    check_val("post4_abs", dout_a, 8'h10);

    // randomized traffic, narrow address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra, rb;
      ra = (n % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rb = (n % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cycle("rnd", 1'($urandom_range(0, 1)), ra, 8'($urandom),
                   1'($urandom_range(0, 1)), rb, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
